// File: rtl/avalon_pos_bank_if.sv
// avalon_pos_bank_if: Avalon-MM slave bus carrying the position bank register accesses.
interface avalon_pos_bank_if #(
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    modport master(output address, chipselect, write_n, writedata, input readdata);
    modport slave(input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/avalon_pos_bank.sv
// avalon_pos_bank: shadow/active position registers committed atomically on frame_sync or on demand.
// Define POSBANK_READBACK_ACTIVE_EN to read back the driven (active) values at SHADOW addresses.
module avalon_pos_bank #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 10,
    parameter int ADDR_W = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    avalon_pos_bank_if.slave        bus,
    input  logic                    frame_sync,
    output logic [NUM_CH*WIDTH-1:0] out_port,
    output logic                    update_pulse
);
    logic [NUM_CH-1:0][WIDTH-1:0] shadow_q, shadow_d, active_q, active_d;
    logic [NUM_CH-1:0]            dirty_q, dirty_d;
    logic                         pending_q, pending_d;
    logic                         update_pulse_q, update_pulse_d;
    logic [7:0]                   commit_count_q, commit_count_d;
    logic [2:0]                   sync_q, sync_d;
    logic                         wr, ctrl_wr, xfer, unused_wd;
    logic [31:0]                  rdata;

    assign wr        = bus.chipselect && !bus.write_n;
    assign ctrl_wr   = wr && bus.address == ADDR_W'(NUM_CH);
    assign xfer      = (ctrl_wr && bus.writedata[1]) || (sync_q[1] && !sync_q[2] && pending_q);
    assign unused_wd = ^bus.writedata;

    always_comb begin
        sync_d   = {sync_q[1:0], frame_sync};
        shadow_d = shadow_q;
        dirty_d  = xfer ? '0 : dirty_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr && bus.address == ADDR_W'(i)) begin
                shadow_d[i] = bus.writedata[WIDTH-1:0];
                dirty_d[i]  = 1'b1;
            end
        end
        // active samples shadow_q, so a same-cycle shadow write lands only in shadow
        active_d       = xfer ? shadow_q : active_q;
        pending_d      = (ctrl_wr && bus.writedata[0] && !bus.writedata[1]) ? 1'b1 : (xfer ? 1'b0 : pending_q);
        commit_count_d = commit_count_q + 8'(xfer);
        update_pulse_d = xfer;
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
`ifdef POSBANK_READBACK_ACTIVE_EN
            if (bus.address == ADDR_W'(i)) rdata = 32'(active_q[i]);
`else
            if (bus.address == ADDR_W'(i)) rdata = 32'(shadow_q[i]);
`endif
        end
        if (bus.address == ADDR_W'(NUM_CH)) rdata = {31'b0, pending_q};
        if (bus.address == ADDR_W'(NUM_CH + 1)) rdata = 32'(dirty_q) | {8'h0, commit_count_q, 16'h0};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q       <= '0;
            active_q       <= '0;
            dirty_q        <= '0;
            pending_q      <= 1'b0;
            commit_count_q <= '0;
            sync_q         <= '0;
            update_pulse_q <= 1'b0;
        end else begin
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            dirty_q        <= dirty_d;
            pending_q      <= pending_d;
            commit_count_q <= commit_count_d;
            sync_q         <= sync_d;
            update_pulse_q <= update_pulse_d;
        end
    end

    assign bus.readdata = rdata;
    assign out_port     = active_q;
    assign update_pulse = update_pulse_q;
endmodule

// File: tb/tb_avalon_pos_bank.sv
// tb_avalon_pos_bank: scoreboard bench for avalon_pos_bank (NUM_CH=4, WIDTH=10, ADDR_W=3).
module tb_avalon_pos_bank;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        frame_sync;
    logic [39:0] out_port;
    logic        update_pulse;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] rd_q[$];
    logic [39:0] out_q[$];
    logic [39:0] exp_out;

    avalon_pos_bank_if #(.ADDR_W(3)) bus();

    avalon_pos_bank #(.NUM_CH(4), .WIDTH(10), .ADDR_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .frame_sync(frame_sync), .out_port(out_port), .update_pulse(update_pulse)
    );

    always #5 clk = ~clk;

`ifdef POSBANK_READBACK_ACTIVE_EN
    localparam logic [31:0] RB_CH2 = 32'h0;
    localparam logic [31:0] RB_CH0 = 32'h123;
`else
    localparam logic [31:0] RB_CH2 = 32'h1FF;
    localparam logic [31:0] RB_CH0 = 32'h2AA;
`endif

    function automatic logic [39:0] pack(input logic [9:0] c3, c2, c1, c0);
        return {c3, c2, c1, c0};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string tag);
        rd_q.push_back(e);
        @(negedge clk);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
        #1;
        check(tag, 64'(bus.readdata), 64'(rd_q.pop_front()));
        bus.chipselect = 1'b0;
    endtask

    // every update_pulse must match exactly one queued commit
    always @(negedge clk) begin
        if (update_pulse) begin
            if (out_q.size() == 0) check("spurious_pulse", 64'(update_pulse), 64'(0));
            else check("pulse_out", 64'(out_port), 64'(out_q.pop_front()));
        end
    end

    initial begin
        reset_n = 1'b0; frame_sync = 1'b0;
        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) rd(3'(a), 32'h0, "reset_read");
        check("reset_out", 64'(out_port), 64'(0));
        check("reset_pulse", 64'(update_pulse), 64'(0));

        wr(3'd2, 32'h1FF);
        frame_sync = 1'b1;
        repeat (4) @(negedge clk);
        frame_sync = 1'b0;
        repeat (4) @(negedge clk);
        check("noarm_out", 64'(out_port), 64'(0));
        rd(3'd5, 32'h4, "noarm_status");
        rd(3'd2, RB_CH2, "noarm_shadow2");

        wr(3'd0, 32'h123);
        wr(3'd3, 32'h3FF);
        wr(3'd4, 32'h1);
        rd(3'd4, 32'h1, "ctrl_armed");
        rd(3'd5, 32'hD, "status_dirty");
        exp_out = pack(10'h3FF, 10'h1FF, 10'h000, 10'h123);
        out_q.push_back(exp_out);
        @(negedge clk);
        frame_sync = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("lat_k", 64'(out_port), 64'(0));
        @(negedge clk);
        check("lat_k1", 64'(out_port), 64'(0));
        @(negedge clk);
        check("lat_k2", 64'(out_port), 64'(exp_out));
        check("pulse_hi", 64'(update_pulse), 64'(1));
        @(negedge clk);
        check("pulse_lo", 64'(update_pulse), 64'(0));
        frame_sync = 1'b0;
        repeat (3) @(negedge clk);
        rd(3'd5, 32'h00010000, "status_commit1");
        rd(3'd4, 32'h0, "ctrl_cleared");

        wr(3'd1, 32'h055);
        check("now_before", 64'(out_port), 64'(exp_out));
        exp_out = pack(10'h3FF, 10'h1FF, 10'h055, 10'h123);
        out_q.push_back(exp_out);
        wr(3'd4, 32'h2);
        check("now_out", 64'(out_port), 64'(exp_out));
        rd(3'd5, 32'h00020000, "status_commit2");

        wr(3'd4, 32'h1);
        out_q.push_back(exp_out);
        frame_sync = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        bus.address = 3'd0; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = 32'h2AA;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
        check("race_active", 64'(out_port), 64'(exp_out));
        repeat (2) @(negedge clk);
        frame_sync = 1'b0;
        repeat (4) @(negedge clk);
        rd(3'd0, RB_CH0, "race_shadow0");
        rd(3'd5, 32'h00030001, "race_status");

        exp_out = pack(10'h3FF, 10'h1FF, 10'h055, 10'h2AA);
        for (int n = 0; n < 253; n++) begin
            out_q.push_back(exp_out);
            wr(3'd4, 32'h2);
            if (n == 251) rd(3'd5, 32'h00FF0000, "status_cnt255");
        end
        rd(3'd5, 32'h0, "status_wrap");
        check("wrap_out", 64'(out_port), 64'(exp_out));

        wr(3'd4, 32'h1);
        rd(3'd4, 32'h1, "ctrl_armed2");
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_out", 64'(out_port), 64'(0));
        check("rst_pulse", 64'(update_pulse), 64'(0));
        rd(3'd4, 32'h0, "rst_ctrl");
        rd(3'd5, 32'h0, "rst_status");
        rd(3'd0, 32'h0, "rst_shadow0");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        rd(3'd4, 32'h0, "ctrl_after_rst");
        check("out_after_rst", 64'(out_port), 64'(0));
        check("commits_seen", 64'(out_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/avalon_pos_bank.md
Name: avalon_pos_bank

Overview:
- Parametrised Avalon-MM slave holding NUM_CH position registers of WIDTH bits each.
- Software writes shadow registers. The shadow values are copied to the active outputs atomically, either on the next frame_sync rising edge after a commit is armed, or immediately on request.
- Drives sprite/object position buses into the video pipeline without mid-frame tearing.

Parameters:
- NUM_CH, 4, number of position channels (1..16).
- WIDTH, 10, bits per channel (1..32).
- ADDR_W, 3, Avalon word-address width; NUM_CH+2 <= 2**ADDR_W is required.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  reset.
- address  input  ADDR_W  Avalon word address.
- chipselect  input  1  Avalon select.
- write_n  input  1  Avalon write strobe, active-low.
- writedata  input  32  Avalon write data.
- readdata  output  32  Avalon read data; combinational, zero wait states.
- frame_sync  input  1  asynchronous frame-start strobe (e.g. vsync); level is at least 3 clk periods wide.
- out_port  output  NUM_CH*WIDTH  active values; channel i occupies bits [i*WIDTH +: WIDTH].
- update_pulse  output  1  one-cycle pulse when out_port was loaded.

Behaviour:
- Reset and clock: reset reset_n, asynchronous, active-low; clock clk.
- Reset values: all shadow = 0, all active = 0, pending = 0, dirty = 0, commit_count = 0, sync flops = 0, update_pulse = 0.
- Address map:
  - 0..NUM_CH-1: SHADOW[i].
  - NUM_CH: CTRL.
  - NUM_CH+1: STATUS.
  - Other addresses: writes ignored, reads return 0.
- Write decode: chipselect && !write_n.
- SHADOW write: shadow[i] <= writedata[WIDTH-1:0]; dirty[i] <= 1.
- CTRL write:
  - bit0 ARM: pending <= 1.
  - bit1 NOW: transfer on the next clk edge; NOW overrides ARM.
  - Other bits ignored.
- CTRL read: bit0 = pending; other bits 0.
- STATUS read: bits[NUM_CH-1:0] = dirty; bits[23:16] = commit_count; other bits 0.
- Read mux: SHADOW read returns zero-extended shadow[i].
- frame_sync synchroniser: 3 flops s1->s2->s3; edge = s2 & ~s3.
- Transfer (on edge && pending, or on a NOW write):
  - active <= shadow (all channels in the same cycle).
  - pending <= 0, dirty <= 0.
  - commit_count <= commit_count+1, wrapping 255->0.
  - update_pulse = 1 in the following cycle only.
- Latency: frame_sync first sampled high at clk edge k → out_port updates at edge k+2 → update_pulse high for the cycle after edge k+2.
- edge while pending=0: no transfer, no count change.
- Simultaneous SHADOW write and transfer: active takes the pre-write shadow value; shadow takes the new value; dirty[i] ends at 1.
- Simultaneous ARM write and edge:
  - If pending was 0: no transfer; pending ends 1.
  - If pending was 1: transfer occurs; pending ends 1 because the new arm wins.
- NOW write and edge+pending in the same cycle: a single transfer; commit_count increments by 1.
- Reset asserted mid-frame or while pending: everything returns to reset values immediately; out_port = 0.

Optional Feature:
- Macro: POSBANK_READBACK_ACTIVE_EN.
- Defined: a SHADOW address read returns active[i] (the value currently driven) instead of shadow[i].
- Undefined: a SHADOW address read returns shadow[i].
- Write behaviour is identical in both builds.

Test Plan:
- Reset, then read all addresses → out_port = 0, SHADOW = 0, CTRL = 0, STATUS = 0.
- Write SHADOW[2] = 0x1FF, with no arm; pulse frame_sync → out_port channel 2 stays 0; STATUS = 0x00000004.
- Write SHADOW[0] = 0x123, SHADOW[3] = 0x3FF; CTRL = 1; raise frame_sync at edge k → out_port ch0 = 0x123, ch3 = 0x3FF at edge k+2; update_pulse high for one cycle; STATUS = 0x00010000; CTRL = 0.
- Write CTRL = 2 (NOW) with SHADOW[1] = 0x055 → out_port ch1 = 0x055 one edge later, with no frame_sync; commit_count increments.
- ARM, then write SHADOW[0] = 0x2AA in the exact transfer cycle → active ch0 = old value; a SHADOW[0] read returns 0x2AA (0x old value if POSBANK_READBACK_ACTIVE_EN); dirty bit0 = 1.
- Perform 256 NOW commits → commit_count wraps to 0; then assert reset_n low while pending=1 → all outputs 0, pending 0.
